// File: rtl/sequence_checker.sv
// rtl/sequence_checker.sv - phase-acquiring checker for the 0,8,5,3,7,2 cyclic code stream
module sequence_checker #(
  parameter int LOCK_COUNT = 3,
  parameter int MISS_LIMIT = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       locked,
  output logic       error,
  output logic       cycle_done,
  output logic [3:0] expected,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] MISS_N = 4'(MISS_LIMIT);

  // Successor in the code cycle; 2 wraps back to 0 and non-members map to 0.
  function automatic logic [3:0] succ(input logic [3:0] s);
    case (s)
      4'd0:    succ = 4'd8;
      4'd8:    succ = 4'd5;
      4'd5:    succ = 4'd3;
      4'd3:    succ = 4'd7;
      4'd7:    succ = 4'd2;
      default: succ = 4'd0;
    endcase
  endfunction

  // True for the six symbols that appear in the code cycle.
  function automatic logic is_member(input logic [3:0] s);
    case (s)
      4'd0, 4'd8, 4'd5, 4'd3, 4'd7, 4'd2: is_member = 1'b1;
      default:                            is_member = 1'b0;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [3:0] run_q, run_d;
  logic [3:0] miss_q, miss_d;
  logic [3:0] exp_q, exp_d;
  logic       error_q, error_d;
  logic       cd_q, cd_d;
  logic [7:0] cnt_q, cnt_d;

  logic [3:0] run_inc;
  logic [3:0] miss_inc;
  logic       match;

  assign run_inc  = run_q + 4'd1;
  assign miss_inc = miss_q + 4'd1;
  assign match    = (in_data == exp_q);

  // State and output registers; reset drops everything to the HUNT idle values at once.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= HUNT;
      run_q   <= 4'd0;
      miss_q  <= 4'd0;
      exp_q   <= 4'd0;
      error_q <= 1'b0;
      cd_q    <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      exp_q   <= exp_d;
      error_q <= error_d;
      cd_q    <= cd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: acquire phase in HUNT/SYNC, then flywheel-predict in LOCKED.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    miss_d  = miss_q;
    exp_d   = exp_q;
    error_d = 1'b0;
    cd_d    = 1'b0;
    cnt_d   = cnt_q;

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (is_member(in_data)) begin
            state_d = SYNC;
            run_d   = 4'd1;
            exp_d   = succ(in_data);
          end
        end

        SYNC: begin
          if (match) begin
            run_d = run_inc;
            exp_d = succ(in_data);
            if (run_inc == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else if (is_member(in_data)) begin
            // A wrong but legal symbol is treated as a fresh phase guess.
            run_d = 4'd1;
            exp_d = succ(in_data);
          end else begin
            state_d = HUNT;
            run_d   = 4'd0;
            exp_d   = 4'd0;
          end
        end

        LOCKED: begin
          if (match) begin
            miss_d = 4'd0;
            exp_d  = succ(exp_q);
            cd_d   = (in_data == 4'd2);
          end else begin
            error_d = 1'b1;
            cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            if (miss_inc == MISS_N) begin
              state_d = HUNT;
              run_d   = 4'd0;
              miss_d  = 4'd0;
              exp_d   = 4'd0;
            end else begin
              // Keep predicting from our own phase, ignoring the corrupted sample.
              miss_d = miss_inc;
              exp_d  = succ(exp_q);
            end
          end
        end

        default: begin
          state_d = HUNT;
          run_d   = 4'd0;
          miss_d  = 4'd0;
          exp_d   = 4'd0;
        end
      endcase
    end
  end

  assign locked     = (state_q == LOCKED);
  assign error      = error_q;
  assign cycle_done = cd_q;
  assign expected   = exp_q;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_sequence_checker.sv
// tb/tb_sequence_checker.sv - randomized self-checking bench with a phase-index reference model
module tb_sequence_checker;

  logic       clock = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic [3:0] in_data;

  logic       locked_o [2];
  logic       error_o  [2];
  logic       cd_o     [2];
  logic [3:0] exp_o    [2];
  logic [7:0] cnt_o    [2];

  always #5 clock = ~clock;

  sequence_checker #(.LOCK_COUNT(3), .MISS_LIMIT(2)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .locked(locked_o[0]), .error(error_o[0]), .cycle_done(cd_o[0]),
    .expected(exp_o[0]), .err_count(cnt_o[0])
  );

  sequence_checker #(.LOCK_COUNT(3), .MISS_LIMIT(15)) dut_sat (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .locked(locked_o[1]), .error(error_o[1]), .cycle_done(cd_o[1]),
    .expected(exp_o[1]), .err_count(cnt_o[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  int seq [6];
  int miss_lim [2];
  int m_mode [2];  // 0 hunting, 1 syncing, 2 locked
  int m_pos  [2];  // index into seq of the predicted next symbol
  int m_run  [2];
  int m_miss [2];
  int m_total[2];  // unsaturated mismatch total
  int m_err  [2];
  int m_cd   [2];
  int cd0_pulses;
  int pulses1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int find(input int d);
    for (int i = 0; i < 6; i++) if (seq[i] == d) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_pos[i] = 0; m_run[i] = 0; m_miss[i] = 0;
      m_total[i] = 0; m_err[i] = 0; m_cd[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit v, input int d);
    int j;
    m_err[i] = 0;
    m_cd[i]  = 0;
    if (!v) return;
    j = find(d);
    if (m_mode[i] == 0) begin
      if (j >= 0) begin m_mode[i] = 1; m_run[i] = 1; m_pos[i] = (j + 1) % 6; end
    end else if (m_mode[i] == 1) begin
      if (d == seq[m_pos[i]]) begin
        m_run[i]++;
        m_pos[i] = (m_pos[i] + 1) % 6;
        if (m_run[i] == 3) begin m_mode[i] = 2; m_miss[i] = 0; end
      end else if (j >= 0) begin
        m_run[i] = 1; m_pos[i] = (j + 1) % 6;
      end else begin
        m_mode[i] = 0; m_run[i] = 0; m_pos[i] = 0;
      end
    end else begin
      if (d == seq[m_pos[i]]) begin
        m_miss[i] = 0;
        m_cd[i]   = (d == 2) ? 1 : 0;
        m_pos[i]  = (m_pos[i] + 1) % 6;
      end else begin
        m_err[i] = 1;
        m_total[i]++;
        m_miss[i]++;
        if (m_miss[i] == miss_lim[i]) begin
          m_mode[i] = 0; m_run[i] = 0; m_miss[i] = 0; m_pos[i] = 0;
        end else begin
          m_pos[i] = (m_pos[i] + 1) % 6;
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("locked[%0d]", i), int'(locked_o[i]), (m_mode[i] == 2) ? 1 : 0);
      check($sformatf("error[%0d]", i), int'(error_o[i]), m_err[i]);
      check($sformatf("cycle_done[%0d]", i), int'(cd_o[i]), m_cd[i]);
      check($sformatf("expected[%0d]", i), int'(exp_o[i]), (m_mode[i] == 0) ? 0 : seq[m_pos[i]]);
      check($sformatf("err_count[%0d]", i), int'(cnt_o[i]), (m_total[i] > 255) ? 255 : m_total[i]);
    end
  endtask

  task automatic drive(input bit v, input int d);
    in_valid = v;
    in_data  = 4'(d);
    @(posedge clock);
    for (int i = 0; i < 2; i++) model_step(i, v, d);
    #1;
    check_outputs();
    if (cd_o[0]) cd0_pulses++;
    if (error_o[1]) pulses1++;
    @(negedge clock);
  endtask

  // Called at a falling edge; reset is asserted and checked well before the next rising edge.
  task automatic do_reset();
    resetn   = 1'b0;
    in_valid = 1'b0;
    #2;
    model_reset();
    check_outputs();
    pulses1 = 0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic play(input int q[$]);
    cd0_pulses = 0;
    foreach (q[k]) begin
      if (q[k] < 0) drive(1'b0, int'($urandom_range(0, 15)));
      else          drive(1'b1, q[k]);
    end
  endtask

  initial begin
    int q[$];
    int d;
    int iter;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'd0;
    seq      = '{0, 8, 5, 3, 7, 2};
    miss_lim = '{2, 15};
    model_reset();
    @(negedge clock);
    do_reset();

    q = {0, 8, 5, 3, 7, 2, 0};
    play(q);
    check("acquire_cycle_done_pulses", cd0_pulses, 1);

    do_reset();
    q = {9, 4, 3, 7, 2};
    play(q);
    check("junk_locked", int'(locked_o[0]), 1);

    do_reset();
    q = {0, 8, 5, 6, 7};
    play(q);
    check("flywheel_err_count", int'(cnt_o[0]), 1);

    q = {9, 9, 5, 3, 7};
    play(q);
    check("relock_after_loss", int'(locked_o[0]), 1);

    do_reset();
    q = {0, -1, 8, -1, -1, 5};
    play(q);
    check("gap_lock", int'(locked_o[0]), 1);
    @(negedge clock);
    do_reset();

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if (m_mode[0] != 0 && $urandom_range(0, 9) < 7) d = seq[m_pos[0]];
      else d = int'($urandom_range(0, 15));
      drive($urandom_range(0, 3) != 0, d);
    end

    do_reset();
    iter = 0;
    while (m_total[1] < 300 && iter < 5000) begin
      iter++;
      if (m_mode[1] == 2) begin
        if (m_miss[1] < 10) d = seq[(m_pos[1] + 1 + int'($urandom_range(0, 4))) % 6];
        else d = seq[m_pos[1]];
      end else if (m_mode[1] == 1) begin
        d = seq[m_pos[1]];
      end else begin
        d = 0;
      end
      drive(1'b1, d);
    end
    check("sat_reached_300", (m_total[1] >= 300) ? 1 : 0, 1);
    check("sat_err_count", int'(cnt_o[1]), 255);
    check("sat_error_pulses", pulses1, m_total[1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
